// File: rtl/serv_cfu.sv
// serv_cfu: custom-function unit for the SERV core.
// Single-command engine: SIMD multiply-accumulate with a programmable input
// offset, accumulator read/write, and a bit-serial 32x32 unsigned multiply.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready for a command (after the first edge out of reset)
// MUL   | shift-add multiply, one multiplier bit per cycle, 32 cycles
// RESP  | result presented, held until the core takes it
module serv_cfu #(
    parameter int WITH_OFFSET = 1
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [2:0]  i_cmd_funct3,
    input  logic [6:0]  i_cmd_funct7,
    input  logic [31:0] i_cmd_rs1,
    input  logic [31:0] i_cmd_rs2,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        run_q;
    logic        accept;
    logic [31:0] acc_q;
    logic [8:0]  off_q;
    logic [4:0]  cnt_q;
    logic [31:0] mcand_q;
    logic [31:0] mplier_q;
    logic [31:0] prod_q;
    logic [31:0] prod_step;
    logic [31:0] rdt_q;
    logic [31:0] mac_sum;
    logic [9:0]  mac_a [4];
    logic [16:0] mac_p [4];
    logic        unused_funct7;

    // Only the clear-on-read modifier bit of funct7 is meaningful.
    assign unused_funct7 = ^i_cmd_funct7[6:1];

    assign accept    = i_cmd_valid && o_cmd_ready;
    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : 32'd0);

    // Four signed byte lanes: (a + off) * b, each 17-bit product sign-extended.
    always_comb begin
        mac_sum = '0;
        for (int i = 0; i < 4; i++) begin
            mac_a[i] = {{2{i_cmd_rs1[8*i+7]}}, i_cmd_rs1[8*i +: 8]} + {off_q[8], off_q};
            mac_p[i] = $signed({{7{mac_a[i][9]}}, mac_a[i]})
                     * $signed({{9{i_cmd_rs2[8*i+7]}}, i_cmd_rs2[8*i +: 8]});
            mac_sum  = mac_sum + {{15{mac_p[i][16]}}, mac_p[i]};
        end
    end

    // State register; run_q keeps ready low until the first edge after reset.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = (i_cmd_funct3 == 3'd4) ? S_MUL : S_RESP;
            S_MUL:   if (cnt_q == 5'd31) state_d = S_RESP;
            S_RESP:  if (i_rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs; the result bus is forced to zero outside RESP.
    always_comb begin
        o_cmd_ready = (state_q == S_IDLE) && run_q;
        o_rsp_valid = (state_q == S_RESP);
        o_rsp_rdt   = (state_q == S_RESP) ? rdt_q : 32'd0;
    end

    // Datapath: single-cycle ops resolve at accept, multiply steps in MUL.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q    <= '0;
            off_q    <= '0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            rdt_q    <= '0;
        end else if (accept) begin
            case (i_cmd_funct3)
                3'd0: begin
                    acc_q <= acc_q + mac_sum;
                    rdt_q <= acc_q + mac_sum;
                end
                3'd1: begin
                    rdt_q <= acc_q;
                    if (i_cmd_funct7[0]) acc_q <= '0;
                end
                3'd2: begin
                    rdt_q <= acc_q;
                    acc_q <= i_cmd_rs1;
                end
                3'd3: begin
                    rdt_q <= '0;
                    if (WITH_OFFSET != 0) off_q <= i_cmd_rs1[8:0];
                end
                3'd4: begin
                    mcand_q  <= i_cmd_rs1;
                    mplier_q <= i_cmd_rs2;
                    prod_q   <= '0;
                    cnt_q    <= '0;
                end
                default: rdt_q <= '0;
            endcase
        end else if (state_q == S_MUL) begin
            prod_q   <= prod_step;
            mcand_q  <= {mcand_q[30:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[31:1]};
            cnt_q    <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) rdt_q <= prod_step;
        end
    end

endmodule

// File: tb/tb_serv_cfu.sv
// Self-checking bench for serv_cfu: directed vector table, hand-written
// backpressure / reset sequences, then random commands against a model.
module tb_serv_cfu;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [2:0]  i_cmd_funct3;
    logic [6:0]  i_cmd_funct7;
    logic [31:0] i_cmd_rs1;
    logic [31:0] i_cmd_rs2;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdt;

    serv_cfu dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_funct3 (i_cmd_funct3),
        .i_cmd_funct7 (i_cmd_funct7),
        .i_cmd_rs1    (i_cmd_rs1),
        .i_cmd_rs2    (i_cmd_rs2),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_rdt    (o_rsp_rdt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] rdt;
        int          lat;
    } vec_t;

    vec_t        vecs[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] acc_m = 0;
    int          off_m = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference model: spec arithmetic on plain ints.
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [6:0] f7,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] old;
        int          s;
        byte         x;
        byte         y;
        old = acc_m;
        case (f3)
            3'd0: begin
                s = 0;
                for (int i = 0; i < 4; i++) begin
                    x = a[8*i +: 8];
                    y = b[8*i +: 8];
                    s += (int'(x) + off_m) * int'(y);
                end
                acc_m = acc_m + s;
                return acc_m;
            end
            3'd1: begin
                if (f7[0]) acc_m = 0;
                return old;
            end
            3'd2: begin
                acc_m = a;
                return old;
            end
            3'd3: begin
                off_m = a[8] ? int'(a[8:0]) - 512 : int'(a[8:0]);
                return 0;
            end
            3'd4: return a * b;
            default: return 0;
        endcase
    endfunction

    // Issue one command from an idle negedge, check latency / result, apply
    // bp cycles of backpressure with an intruding command, then hand-shake.
    task automatic run_op(input string nm, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_rdt, input int exp_lat, input int bp);
        int          n;
        bit          rdy_bad;
        bit          rdt_bad;
        bit          stab_bad;
        logic [31:0] got;
        rdy_bad  = 0;
        rdt_bad  = 0;
        stab_bad = 0;
        check({nm, " ready_before"}, 32'(o_cmd_ready), 32'd1);
        i_cmd_valid  = 1'b1;
        i_cmd_funct3 = f3;
        i_cmd_funct7 = f7;
        i_cmd_rs1    = a;
        i_cmd_rs2    = b;
        @(posedge clk);
        @(negedge clk);
        i_cmd_valid  = 1'b0;
        i_cmd_funct3 = 3'($urandom);
        i_cmd_funct7 = 7'($urandom);
        i_cmd_rs1    = $urandom;
        i_cmd_rs2    = $urandom;
        n = 1;
        while (!o_rsp_valid && n < 100) begin
            if (o_cmd_ready) rdy_bad = 1;
            if (o_rsp_rdt != 0) rdt_bad = 1;
            @(negedge clk);
            n++;
        end
        check({nm, " latency"}, 32'(n), 32'(exp_lat));
        check({nm, " rdt"}, o_rsp_rdt, exp_rdt);
        check({nm, " busy_flags"}, {30'd0, rdy_bad, rdt_bad}, 32'd0);
        got = o_rsp_rdt;
        for (int k = 0; k < bp; k++) begin
            i_cmd_valid  = 1'b1;
            i_cmd_funct3 = 3'd2;
            i_cmd_rs1    = 32'h1234_5678;
            @(negedge clk);
            if (!o_rsp_valid || o_rsp_rdt !== got || o_cmd_ready) stab_bad = 1;
        end
        check({nm, " hold_stable"}, 32'(stab_bad), 32'd0);
        i_rsp_ready = 1'b1;
        @(negedge clk);
        i_rsp_ready = 1'b0;
        i_cmd_valid = 1'b0;
        check({nm, " back_idle"}, {30'd0, o_cmd_ready, o_rsp_valid}, 32'd2);
    endtask

    function automatic void add_vec(input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] r, input int lat);
        vec_t v;
        v.f3 = f3; v.f7 = f7; v.rs1 = a; v.rs2 = b; v.rdt = r; v.lat = lat;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        bit          saw_rsp;

        add_vec(3'd0, 7'd0, 32'h0403_0201, 32'h0101_0101, 32'h0000_000A, 1);
        add_vec(3'd1, 7'd0, 32'h0,         32'h0,         32'h0000_000A, 1);
        add_vec(3'd3, 7'd0, 32'h0000_0080, 32'h0,         32'h0,         1);
        add_vec(3'd0, 7'd0, 32'h8080_8080, 32'h7F7F_7F7F, 32'h0000_000A, 1);
        add_vec(3'd0, 7'd0, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FE0A, 1);
        add_vec(3'd4, 7'd0, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 33);
        add_vec(3'd2, 7'd0, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FE0A, 1);
        add_vec(3'd3, 7'd0, 32'h0000_0000, 32'h0,         32'h0,         1);
        add_vec(3'd0, 7'd0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1);
        add_vec(3'd1, 7'd1, 32'h0,         32'h0,         32'h0000_0000, 1);
        add_vec(3'd1, 7'd0, 32'h0,         32'h0,         32'h0000_0000, 1);
        add_vec(3'd5, 7'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1);
        add_vec(3'd6, 7'd1, 32'h1,         32'h1,         32'h0,         1);
        add_vec(3'd7, 7'd0, 32'h5,         32'h5,         32'h0,         1);
        add_vec(3'd3, 7'd0, 32'h0000_01FF, 32'h0,         32'h0,         1);
        add_vec(3'd0, 7'd0, 32'h0202_0202, 32'h0303_0303, 32'h0000_000C, 1);
        add_vec(3'd3, 7'd0, 32'hFFFF_FE05, 32'h0,         32'h0,         1);
        add_vec(3'd0, 7'd0, 32'h0000_0000, 32'h0101_0101, 32'h0000_0020, 1);
        add_vec(3'd1, 7'd1, 32'h0,         32'h0,         32'h0000_0020, 1);
        add_vec(3'd1, 7'd0, 32'h0,         32'h0,         32'h0000_0000, 1);
        add_vec(3'd4, 7'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33);
        add_vec(3'd4, 7'd0, 32'h8000_0001, 32'h8000_0001, 32'h0000_0001, 33);

        i_rst_n      = 1'b0;
        i_cmd_valid  = 1'b0;
        i_cmd_funct3 = 3'd0;
        i_cmd_funct7 = 7'd0;
        i_cmd_rs1    = 32'd0;
        i_cmd_rs2    = 32'd0;
        i_rsp_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", {o_cmd_ready, o_rsp_valid, o_rsp_rdt[29:0]}, 32'd0);
        i_rst_n = 1'b1;
        #1;
        check("ready low at release", 32'(o_cmd_ready), 32'd0);
        @(negedge clk);
        check("ready after first edge", 32'(o_cmd_ready), 32'd1);

        foreach (vecs[i]) begin
            e = ref_op(vecs[i].f3, vecs[i].f7, vecs[i].rs1, vecs[i].rs2);
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].f7, vecs[i].rs1,
                   vecs[i].rs2, vecs[i].rdt, vecs[i].lat, 0);
        end

        // Backpressure: held result, intruding ACC_WR must be ignored.
        e = ref_op(3'd2, 7'd0, 32'hCAFE_0001, 32'h0);
        run_op("bp acc_wr", 3'd2, 7'd0, 32'hCAFE_0001, 32'h0, e, 1, 5);
        e = ref_op(3'd1, 7'd0, 32'h0, 32'h0);
        run_op("bp acc_rd", 3'd1, 7'd0, 32'h0, 32'h0, e, 1, 0);
        e = ref_op(3'd4, 7'd0, 32'h0000_1234, 32'h0000_5678);
        run_op("bp mul", 3'd4, 7'd0, 32'h0000_1234, 32'h0000_5678, e, 33, 5);
        e = ref_op(3'd1, 7'd0, 32'h0, 32'h0);
        run_op("bp acc_rd2", 3'd1, 7'd0, 32'h0, 32'h0, e, 1, 0);

        for (int r = 0; r < 200; r++) begin
            f3 = 3'($urandom_range(0, 7));
            if (f3 == 3'd4 && $urandom_range(0, 3) != 0) f3 = 3'd0;
            f7 = 7'($urandom);
            a  = $urandom;
            b  = $urandom;
            e  = ref_op(f3, f7, a, b);
            run_op($sformatf("rnd%0d f3=%0d", r, f3), f3, f7, a, b, e,
                   (f3 == 3'd4) ? 33 : 1, $urandom_range(0, 3));
        end

        // Make acc and off non-zero, then reset in the middle of a multiply.
        e = ref_op(3'd3, 7'd0, 32'h0000_0011, 32'h0);
        run_op("pre-rst set_off", 3'd3, 7'd0, 32'h0000_0011, 32'h0, e, 1, 0);
        e = ref_op(3'd2, 7'd0, 32'h5555_AAAA, 32'h0);
        run_op("pre-rst acc_wr", 3'd2, 7'd0, 32'h5555_AAAA, 32'h0, e, 1, 0);
        i_cmd_valid  = 1'b1;
        i_cmd_funct3 = 3'd4;
        i_cmd_rs1    = 32'hDEAD_BEEF;
        i_cmd_rs2    = 32'h0BAD_F00D;
        @(posedge clk);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("async reset outputs", {o_cmd_ready, o_rsp_valid, o_rsp_rdt[29:0]}, 32'd0);
        check("async reset rdt", o_rsp_rdt, 32'd0);
        saw_rsp = 0;
        i_rsp_ready = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (o_rsp_valid) saw_rsp = 1;
        end
        i_rst_n = 1'b1;
        repeat (3) @(negedge clk);
        if (o_rsp_valid) saw_rsp = 1;
        i_rsp_ready = 1'b0;
        check("no response after reset", 32'(saw_rsp), 32'd0);
        acc_m = 0;
        off_m = 0;
        e = ref_op(3'd1, 7'd0, 32'h0, 32'h0);
        run_op("post-rst acc_rd", 3'd1, 7'd0, 32'h0, 32'h0, e, 1, 0);
        e = ref_op(3'd0, 7'd0, 32'h0, 32'h0101_0101);
        run_op("post-rst off zero", 3'd0, 7'd0, 32'h0, 32'h0101_0101, e, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
